// File: rtl/sequential_divider_pkg.sv
// Shared types and constants for the signed sequential divider.
package sequential_divider_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int LATENCY       = WIDTH_DEFAULT + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, pick quotient bit.
module divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // One extra bit so the borrow of the trial subtract is visible.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {1'b0, div_i};
      if (trial[WIDTH]) begin
         rem_o = shifted[WIDTH-1:0];
         q_o   = 1'b0;
      end else begin
         rem_o = trial[WIDTH-1:0];
         q_o   = 1'b1;
      end
   end

endmodule

// File: rtl/sequential_divider.sv
// Signed restoring divider, one quotient bit per enabled cycle.
// state   | meaning
// IDLE    | waiting for start; captures operand magnitudes and signs
// RUN     | WIDTH restoring steps, counter counts down to terminal count 1
// FIX     | applies signs to quotient and remainder, loads result registers
// DONE    | done=1 for one enabled cycle, then back to IDLE
module sequential_divider
   import sequential_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   // quo_q starts as |a| and is shifted left; quotient bits fill in from the bottom.
   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .bit_i (quo_q[WIDTH-1]),
      .div_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (b == '0) begin
                  q_out_d = '1;
                  r_out_d = a;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  a_neg_d = a[WIDTH-1];
                  b_neg_d = b[WIDTH-1];
                  quo_d   = a[WIDTH-1] ? -a : a;
                  dvs_d   = b[WIDTH-1] ? -b : b;
                  rem_d   = '0;
                  cnt_d   = CNT_LOAD;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            // Magnitude of -2^(WIDTH-1) wraps back to itself, giving the required result.
            q_out_d = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
            r_out_d = a_neg_q ? -rem_q : rem_q;
            dbz_d   = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_out_q <= '0;
         r_out_q <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = q_out_q;
   assign remainder   = r_out_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized self-checking bench for sequential_divider against an arithmetic reference.
module tb_sequential_divider;

   localparam int W   = 32;
   localparam int LAT = W + 2;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   sequential_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .start       (start),
      .a           (a),
      .b           (b),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Truncating signed division; the one overflow case is resolved by WIDTH-bit wrap.
   function automatic void model(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      if (bv == 0) begin
         q = '1; r = av; dz = 1'b1;
      end else if (av == MIN_NEG && bv == -1) begin
         q = MIN_NEG; r = '0; dz = 1'b0;
      end else begin
         q = av / bv; r = av % bv; dz = 1'b0;
      end
   endfunction

   task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int gap_at, input int gap_len, input int restart_at, input int hold_done);
      int n;
      int exp_lat;
      logic [W-1:0] eq, er;
      logic edz;
      logic busy_ok;
      model(av, bv, eq, er, edz);
      exp_lat = (bv == '0) ? 1 : LAT + ((gap_at > 0) ? gap_len : 0);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      n = 1;
      busy_ok = 1'b1;
      while (!done && n < 300) begin
         if (!busy) busy_ok = 1'b0;
         start = (n == restart_at);
         if (gap_at > 0 && n == gap_at) en = 1'b0;
         if (gap_at > 0 && n == gap_at + gap_len) en = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      en = 1'b1;
      chk("latency", W'(n), W'(exp_lat));
      chk("busy_during", {31'b0, busy_ok}, 32'd1);
      chk("done", {31'b0, done}, 32'd1);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, edz});
      // A start coinciding with DONE must be dropped; optionally stretch DONE via en.
      start = 1'b1; a = $urandom; b = $urandom;
      if (hold_done > 0) begin
         en = 1'b0;
         for (int i = 0; i < hold_done; i++) begin
            @(posedge clk); #1;
            chk("done_stretch", {31'b0, done}, 32'd1);
         end
         en = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_pulse_end", {31'b0, done}, 32'd0);
      chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("quotient_hold", quotient, eq);
      chk("remainder_hold", remainder, er);
   endtask

   initial begin
      int done_seen;
      logic [W-1:0] ra, rb;
      int mode;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_quotient", quotient, '0);
      chk("rst_remainder", remainder, '0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

      do_div(32'd100, 32'd7, 0, 0, 0, 0);
      do_div(-32'sd100, 32'd7, 0, 0, 0, 0);
      do_div(32'd100, -32'sd7, 0, 0, 0, 0);
      do_div(-32'sd100, -32'sd7, 0, 0, 0, 0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
      do_div(32'd5, 32'd0, 0, 0, 0, 0);
      do_div(32'd100, 32'd7, 12, 5, 6, 0);
      do_div(-32'sd12345, 32'd0, 0, 0, 0, 3);
      do_div(32'd99, 32'd10, 0, 0, 0, 2);

      // Abort mid-run with reset while en is low.
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      en = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; en = 1'b1;
      chk("abort_quotient", quotient, '0);
      chk("abort_remainder", remainder, '0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_seen++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", W'(done_seen), '0);
      do_div(32'd553524, 32'd840, 0, 0, 0, 0);

      for (int t = 0; t < 40; t++) begin
         mode = $urandom_range(0, 4);
         ra = $urandom; rb = $urandom;
         if (mode == 1) begin
            ra = W'(int'($urandom_range(0, 2000)) - 1000);
            rb = W'(int'($urandom_range(1, 40)) - 20);
         end else if (mode == 2) begin
            rb = '0;
         end else if (mode == 3) begin
            ra = MIN_NEG;
            rb = ($urandom_range(0, 1) == 1) ? '1 : rb;
         end else if (mode == 4) begin
            rb = rb >> $urandom_range(0, 31);
         end
         if ($urandom_range(0, 3) == 0)
            do_div(ra, rb, $urandom_range(2, 30), $urandom_range(1, 6), $urandom_range(2, 30), $urandom_range(0, 2));
         else
            do_div(ra, rb, 0, 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
